// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if -- request/SPI-master/data-register bundle for the
// SPI transfer arbiter.
//   req, enable_mask : per-slave transfer request and enable (to arbiter)
//   spi_busy         : SPI master busy, SPI clock domain (to arbiter)
//   ack, err         : per-slave completion / timeout pulses (from arbiter)
//   spi_select       : one-hot slave select, spi_start : start request
//   tx_reg_addr      : TX data-register address of the granted slave
//   rx_reg_en/addr   : RX data-register write strobe and address
//   active           : arbiter not idle, cur_slave : granted slave index
interface spi_xfer_arbiter_if;
  logic [7:0] req;
  logic [7:0] enable_mask;
  logic       spi_busy;
  logic [7:0] ack;
  logic [7:0] err;
  logic [7:0] spi_select;
  logic       spi_start;
  logic [7:0] tx_reg_addr;
  logic       rx_reg_en;
  logic [7:0] rx_reg_addr;
  logic       active;
  logic [2:0] cur_slave;

  // slave: the arbiter itself
  modport slave (
    input  req, enable_mask, spi_busy,
    output ack, err, spi_select, spi_start, tx_reg_addr,
           rx_reg_en, rx_reg_addr, active, cur_slave
  );

  // master: whoever raises requests and plays the SPI master
  modport master (
    output req, enable_mask, spi_busy,
    input  ack, err, spi_select, spi_start, tx_reg_addr,
           rx_reg_en, rx_reg_addr, active, cur_slave
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter -- round-robin arbiter granting one of 8 slaves access to
// a single SPI master, with per-transfer timeout and an idle gap between
// transfers.
//   ACLK  : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : spi_xfer_arbiter_if.slave (requests, SPI master handshake,
//           data-register addressing, status)
// Parameters: GAP_CYC (>=1) idle cycles between transfers, TIMEOUT_CYC max
// cycles in START+XFER, TX_BASE / RX_BASE data-register base addresses.
module spi_xfer_arbiter #(
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [7:0]  TX_BASE     = 8'h00,
  parameter logic [7:0]  RX_BASE     = 8'h08
) (
  input  logic               ACLK,
  input  logic               reset,
  spi_xfer_arbiter_if.slave  bus
);
  localparam int NUM_SLV = 8;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GLIM = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_XFER, S_CAPTURE, S_ABORT, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, cur_q;
  logic [TW-1:0]   tcnt_q;
  logic [GW-1:0]   gcnt_q;
  logic            busy_m, busy_s;
  logic [7:0]      elig, sel_oh;
  logic            gnt_vld, tmo, gap_done;
  logic [2:0]      gnt_idx, rr_idx;

  // 2-flop synchronizer: spi_busy comes from the SPI clock domain
  always_ff @(posedge ACLK) begin
    if (reset) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= bus.spi_busy;
      busy_s <= busy_m;
    end
  end

  // Round-robin pick: first eligible index starting at ptr, wrapping mod 8
  always_comb begin
    elig    = bus.req & bus.enable_mask;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rr_idx = ptr_q + 3'(i);
      if (!gnt_vld && elig[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  assign sel_oh   = 8'b1 << cur_q;
  assign tmo      = (tcnt_q == TLIM);
  assign gap_done = (gcnt_q == GLIM);

  always_ff @(posedge ACLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and outputs; all outputs decode from the registered state so
  // they drop to 0 the cycle after reset is taken.
  always_comb begin
    state_d         = state_q;
    bus.ack         = '0;
    bus.err         = '0;
    bus.spi_select  = '0;
    bus.spi_start   = 1'b0;
    bus.tx_reg_addr = '0;
    bus.rx_reg_en   = 1'b0;
    bus.rx_reg_addr = '0;
    bus.active      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:    if (gnt_vld) state_d = S_START;
      S_START: begin
        bus.spi_start   = 1'b1;
        bus.spi_select  = sel_oh;
        bus.tx_reg_addr = TX_BASE + {5'b0, cur_q};
        // timeout wins over the busy handshake
        if (tmo)         state_d = S_ABORT;
        else if (busy_s) state_d = S_XFER;
      end
      S_XFER: begin
        bus.spi_select  = sel_oh;
        bus.tx_reg_addr = TX_BASE + {5'b0, cur_q};
        if (tmo)          state_d = S_ABORT;
        else if (!busy_s) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        bus.rx_reg_en   = 1'b1;
        bus.rx_reg_addr = RX_BASE + {5'b0, cur_q};
        bus.ack         = sel_oh;
        state_d         = S_GAP;
      end
      S_ABORT: begin
        bus.err = sel_oh;
        state_d = S_GAP;
      end
      S_GAP:     if (gap_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Grant, round-robin pointer, timeout and gap counters
  always_ff @(posedge ACLK) begin
    if (reset) begin
      ptr_q  <= '0;
      cur_q  <= '0;
      tcnt_q <= '0;
      gcnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (gnt_vld) begin
          cur_q  <= gnt_idx;
          tcnt_q <= '0;
        end
        S_START, S_XFER: tcnt_q <= tcnt_q + 1'b1;
        S_CAPTURE, S_ABORT: begin
          ptr_q  <= cur_q + 3'd1;
          gcnt_q <= '0;
        end
        S_GAP:   gcnt_q <= gcnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.cur_slave = cur_q;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter -- scenario tasks driving requests and an SPI master
// model; expected ack/err pairs go into a queue as each transfer is requested
// and are popped when the arbiter reports completion.
module tb_spi_xfer_arbiter;
  logic aclk = 1'b0;
  logic rst  = 1'b1;
  always #5 aclk = ~aclk;

  spi_xfer_arbiter_if bus();

  spi_xfer_arbiter #(
    .GAP_CYC(4), .TIMEOUT_CYC(16), .TX_BASE(8'h00), .RX_BASE(8'h08)
  ) dut (
    .ACLK(aclk), .reset(rst), .bus(bus)
  );

  typedef struct packed {
    logic [7:0] ack;
    logic [7:0] err;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] grants[$];
  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0, rx_cnt = 0, evt_cnt = 0;
  bit rx_bad = 0, multi_bad = 0, sel_bad = 0, start_d = 0;
  bit busy_en = 1;
  int busy_len = 3;

  always @(posedge aclk) cyc <= cyc + 1;

  // SPI master model: raise busy once start is seen, hold busy_len cycles
  initial begin
    bus.spi_busy = 1'b0;
    forever begin
      @(negedge aclk);
      if (bus.spi_start && busy_en && !bus.spi_busy) begin
        bus.spi_busy = 1'b1;
        repeat (busy_len) @(negedge aclk);
        bus.spi_busy = 1'b0;
      end
    end
  end

  // Passive monitor: logs grants and flags protocol violations
  initial begin
    forever begin
      @(negedge aclk);
      if (bus.spi_start && !start_d) begin
        grants.push_back(bus.cur_slave);
        start_cyc = cyc;
      end
      start_d = bus.spi_start;
      if (bus.rx_reg_en) begin
        rx_cnt++;
        if (bus.ack == 8'h00 || bus.rx_reg_addr !== 8'h08 + {5'b0, bus.cur_slave}) rx_bad = 1;
      end
      if ((bus.ack | bus.err) != 8'h00) begin
        evt_cnt++;
        if ($countones(bus.ack | bus.err) != 1 || (bus.ack != 0 && bus.err != 0)) multi_bad = 1;
      end
      if (bus.spi_select != 8'h00 && !(bus.spi_start || (bus.active && !bus.rx_reg_en && bus.ack == 0 && bus.err == 0)))
        sel_bad = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge aclk);
    rst = 1'b1;
    repeat (2) @(negedge aclk);
    rst = 1'b0;
  endtask

  task automatic wait_start(output bit to);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (bus.spi_start) begin to = 0; break; end
    end
  endtask

  task automatic wait_xfer(output bit to);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (bus.active && !bus.spi_start && bus.spi_select != 0) begin to = 0; break; end
    end
  endtask

  task automatic wait_done(output logic [7:0] a, output logic [7:0] e, output logic ren,
                           output logic [7:0] ra, output int dc, output bit to);
    to = 1; a = '0; e = '0; ren = 0; ra = '0; dc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if ((bus.ack | bus.err) != 8'h00) begin
        a = bus.ack; e = bus.err; ren = bus.rx_reg_en; ra = bus.rx_reg_addr;
        dc = cyc; to = 0;
        break;
      end
    end
  endtask

  // Counts cycles after the completion pulse until active drops
  task automatic count_gap(output int n, output bit selnz);
    n = 0; selnz = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (!bus.active) break;
      n++;
      if (bus.spi_select != 8'h00) selnz = 1;
    end
  endtask

  task automatic test_reset();
    logic [45:0] outs;
    bus.req = 8'h00; bus.enable_mask = 8'hFF; rst = 1'b1;
    repeat (3) @(negedge aclk);
    outs = {bus.ack, bus.err, bus.spi_select, bus.spi_start, bus.tx_reg_addr,
            bus.rx_reg_en, bus.rx_reg_addr, bus.active, bus.cur_slave};
    tests++;
    if (outs !== 46'h0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    repeat (3) @(negedge aclk);
    tests++;
    if (bus.active !== 1'b0) begin fails++; $display("FAIL reset_idle: active=%b want 0", bus.active); end
  endtask

  task automatic test_single();
    logic [7:0] a, e, ra; logic ren; int dc, n; bit to, selnz; exp_t x;
    busy_en = 1; busy_len = 3;
    @(negedge aclk);
    bus.req = 8'h04; bus.enable_mask = 8'hFF;
    exp_q.push_back('{ack: 8'h04, err: 8'h00});
    @(negedge aclk);
    tests++;
    if (bus.spi_start !== 1'b1 || bus.spi_select !== 8'h04 || bus.tx_reg_addr !== 8'h02) begin
      fails++;
      $display("FAIL single_start: start=%b sel=%h tx=%h want 1 04 02", bus.spi_start, bus.spi_select, bus.tx_reg_addr);
    end
    bus.req = 8'h00;
    wait_done(a, e, ren, ra, dc, to);
    x = exp_q.pop_front();
    tests++;
    if (to || a !== x.ack || e !== x.err) begin
      fails++; $display("FAIL single_ack: ack=%h err=%h to=%0d want %h %h", a, e, to, x.ack, x.err);
    end
    tests++;
    if (ren !== 1'b1 || ra !== 8'h0A) begin
      fails++; $display("FAIL single_rx: en=%b addr=%h want 1 0a", ren, ra);
    end
    count_gap(n, selnz);
    tests++;
    if (n != 4 || selnz) begin fails++; $display("FAIL single_gap: cycles=%0d selnz=%0d want 4 0", n, selnz); end
  endtask

  task automatic test_round_robin();
    logic [7:0] a, e, ra; logic ren; int dc; bit to; exp_t x;
    logic [2:0] want[4];
    want[0] = 3'd0; want[1] = 3'd7; want[2] = 3'd0; want[3] = 3'd7;
    do_reset();
    grants.delete();
    busy_len = 3;
    for (int k = 0; k < 4; k++) exp_q.push_back('{ack: 8'h01 << want[k], err: 8'h00});
    bus.req = 8'h81; bus.enable_mask = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      wait_done(a, e, ren, ra, dc, to);
      if (k == 3) bus.req = 8'h00;
      x = exp_q.pop_front();
      tests++;
      if (to || a !== x.ack || e !== x.err) begin
        fails++; $display("FAIL rr_ack%0d: ack=%h err=%h to=%0d want %h %h", k, a, e, to, x.ack, x.err);
      end
    end
    repeat (8) @(negedge aclk);
    tests++;
    if (grants.size() != 4) begin
      fails++; $display("FAIL rr_grant_count: got %0d want 4", grants.size());
    end else begin
      for (int k = 0; k < 4; k++)
        if (grants[k] !== want[k]) begin
          fails++; $display("FAIL rr_order%0d: got %0d want %0d", k, grants[k], want[k]);
          break;
        end
    end
  endtask

  task automatic test_masking();
    logic [7:0] a, e, ra; logic ren; int dc; bit to, bad; exp_t x;
    grants.delete();
    exp_q.push_back('{ack: 8'h02, err: 8'h00});
    exp_q.push_back('{ack: 8'h02, err: 8'h00});
    bus.req = 8'h03; bus.enable_mask = 8'h02;
    for (int k = 0; k < 2; k++) begin
      wait_done(a, e, ren, ra, dc, to);
      if (k == 1) bus.req = 8'h00;
      x = exp_q.pop_front();
      tests++;
      if (to || a !== x.ack || e !== x.err) begin
        fails++; $display("FAIL mask_ack%0d: ack=%h err=%h to=%0d want %h %h", k, a, e, to, x.ack, x.err);
      end
    end
    repeat (8) @(negedge aclk);
    bad = (grants.size() != 2);
    foreach (grants[k]) if (grants[k] !== 3'd1) bad = 1;
    tests++;
    if (bad) begin fails++; $display("FAIL mask_grants: count=%0d want 2, all slave 1", grants.size()); end
    bus.enable_mask = 8'hFF;
  endtask

  task automatic test_timeout();
    logic [7:0] a, e, ra; logic ren; int dc, n, rx0; bit to, selnz; exp_t x;
    busy_en = 0;
    rx0 = rx_cnt;
    exp_q.push_back('{ack: 8'h00, err: 8'h08});
    bus.req = 8'h08;
    wait_done(a, e, ren, ra, dc, to);
    bus.req = 8'h00;
    x = exp_q.pop_front();
    tests++;
    if (to || a !== x.ack || e !== x.err) begin
      fails++; $display("FAIL tmo_err: ack=%h err=%h to=%0d want %h %h", a, e, to, x.ack, x.err);
    end
    tests++;
    if (dc - start_cyc != 16) begin fails++; $display("FAIL tmo_latency: got %0d want 16", dc - start_cyc); end
    count_gap(n, selnz);
    tests++;
    if (rx_cnt != rx0 || n != 4 || bus.active !== 1'b0) begin
      fails++; $display("FAIL tmo_after: rx=%0d gap=%0d active=%b want 0 4 0", rx_cnt - rx0, n, bus.active);
    end
    busy_en = 1;
  endtask

  task automatic test_drop_req();
    logic [7:0] a, e, ra; logic ren; int dc; bit to, tx; exp_t x;
    busy_len = 4;
    exp_q.push_back('{ack: 8'h20, err: 8'h00});
    bus.req = 8'h20;
    wait_xfer(tx);
    bus.req = 8'h00; bus.enable_mask = 8'h00;
    wait_done(a, e, ren, ra, dc, to);
    x = exp_q.pop_front();
    tests++;
    if (tx || to || a !== x.ack || e !== x.err) begin
      fails++; $display("FAIL drop_ack: ack=%h err=%h to=%0d want %h %h", a, e, to | tx, x.ack, x.err);
    end
    bus.enable_mask = 8'hFF;
    repeat (8) @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, e, ra; logic ren; int dc, ev0, rx0; bit to, tx; exp_t x;
    logic [45:0] outs;
    busy_len = 8;
    grants.delete();
    bus.req = 8'h10;
    wait_xfer(tx);
    ev0 = evt_cnt; rx0 = rx_cnt;
    rst = 1'b1;
    @(negedge aclk);
    outs = {bus.ack, bus.err, bus.spi_select, bus.spi_start, bus.tx_reg_addr,
            bus.rx_reg_en, bus.rx_reg_addr, bus.active, bus.cur_slave};
    tests++;
    if (tx || outs !== 46'h0) begin fails++; $display("FAIL midrst_outputs: got %h to=%0d want 0", outs, tx); end
    @(negedge aclk);
    rst = 1'b0; bus.req = 8'h00;
    repeat (12) @(negedge aclk);
    tests++;
    if (evt_cnt != ev0 || rx_cnt != rx0) begin
      fails++; $display("FAIL midrst_silent: events=%0d rx=%0d want 0 0", evt_cnt - ev0, rx_cnt - rx0);
    end
    // ptr back at 0: slave 0 wins over slave 7
    busy_len = 3;
    exp_q.push_back('{ack: 8'h01, err: 8'h00});
    bus.req = 8'h81;
    wait_done(a, e, ren, ra, dc, to);
    bus.req = 8'h00;
    x = exp_q.pop_front();
    tests++;
    if (to || a !== x.ack || e !== x.err) begin
      fails++; $display("FAIL midrst_ptr: ack=%h err=%h to=%0d want %h %h", a, e, to, x.ack, x.err);
    end
    repeat (8) @(negedge aclk);
  endtask

  task automatic test_invariants();
    tests++;
    if (rx_bad || multi_bad || sel_bad) begin
      fails++; $display("FAIL invariants: rx_bad=%0d multi=%0d sel_bad=%0d want 0 0 0", rx_bad, multi_bad, sel_bad);
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left: %0d want 0", exp_q.size()); end
  endtask

  initial begin
    bus.req = 8'h00;
    bus.enable_mask = 8'hFF;
    test_reset();
    test_single();
    test_round_robin();
    test_masking();
    test_timeout();
    test_drop_req();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
